// File: rtl/bios_watchdog.sv
// BIOS boot watchdog: LPC-armed down-counter that requests a platform
// reset and flips the BIOS image select when BIOS stops kicking it.
module bios_watchdog #(
   parameter int TICK_DIV     = 33000,
   parameter int TIMEOUT_UNIT = 1024,
   parameter int RST_PULSE    = 16,
   parameter int CNT_W        = 15
) (
   input  logic             LpcClock,
   input  logic             PciReset,
   input  logic             WriteBiosWD,
   input  logic [7:0]       DataWr,
   output logic             WdEnabled,
   output logic             WdExpired,
   output logic             ResetReq,
   output logic             BiosSwap,
   output logic [1:0]       ExpireCnt,
   output logic [CNT_W-1:0] RemainTicks
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int RW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      EXPIRED
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             expired_q, expired_d;
   logic             swap_q, swap_d;
   logic [1:0]       xcnt_q, xcnt_d;
   logic             rreq_q, rreq_d;
   logic [RW-1:0]    rcnt_q, rcnt_d;

   logic             wr_enable;
   logic             wr_clear;
   logic [3:0]       wr_sel;
   logic [CNT_W-1:0] reload;
   logic             tick;
   logic             expire;
   logic             unused_rsvd;

   assign wr_enable   = DataWr[7];
   assign wr_clear    = DataWr[6];
   assign wr_sel      = DataWr[3:0];
   assign unused_rsvd = ^DataWr[5:4];

   assign reload = CNT_W'((32'(wr_sel) + 32'd1) * 32'(TIMEOUT_UNIT));

   assign tick = (state_q == ARMED) &&
                 (presc_q == PW'(TICK_DIV - 1));

   // A write in the final tick cycle reloads instead of expiring
   assign expire = tick && !WriteBiosWD &&
                   (remain_q == CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      remain_d  = remain_q;
      expired_d = expired_q;
      swap_d    = swap_q;
      xcnt_d    = xcnt_q;
      if (WriteBiosWD) begin
         if (!wr_enable) begin
            state_d  = IDLE;
            remain_d = '0;
            presc_d  = '0;
            if (wr_clear) expired_d = 1'b0;
         end else if (state_q != EXPIRED || wr_clear) begin
            state_d  = ARMED;
            remain_d = reload;
            presc_d  = '0;
            if (wr_clear) expired_d = 1'b0;
         end
      end else if (state_q == ARMED) begin
         if (tick) begin
            presc_d = '0;
            if (expire) begin
               state_d   = EXPIRED;
               remain_d  = '0;
               expired_d = 1'b1;
               swap_d    = ~swap_q;
               if (xcnt_q != 2'd3) xcnt_d = xcnt_q + 2'd1;
            end else if (remain_q != '0) begin
               remain_d = remain_q - CNT_W'(1);
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Pulse timer runs on its own once started; writes do not touch it
   always_comb begin
      rreq_d = rreq_q;
      rcnt_d = rcnt_q;
      if (expire) begin
         rreq_d = 1'b1;
         rcnt_d = RW'(RST_PULSE - 1);
      end else if (rreq_q) begin
         if (rcnt_q == '0) rreq_d = 1'b0;
         else rcnt_d = rcnt_q - RW'(1);
      end
   end

   always_ff @(posedge LpcClock) begin
      if (PciReset) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         remain_q  <= '0;
         expired_q <= 1'b0;
         swap_q    <= 1'b0;
         xcnt_q    <= 2'd0;
         rreq_q    <= 1'b0;
         rcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         remain_q  <= remain_d;
         expired_q <= expired_d;
         swap_q    <= swap_d;
         xcnt_q    <= xcnt_d;
         rreq_q    <= rreq_d;
         rcnt_q    <= rcnt_d;
      end
   end

   assign WdEnabled   = (state_q != IDLE);
   assign WdExpired   = expired_q;
   assign ResetReq    = rreq_q;
   assign BiosSwap    = swap_q;
   assign ExpireCnt   = xcnt_q;
   assign RemainTicks = remain_q;

endmodule

// File: doc/bios_watchdog.md
Name: bios_watchdog

Overview:
- BIOS boot watchdog. It sits directly downstream of the LPC top and consumes its `WriteBiosWD` strobe and `DataWr` byte (register 0x01 writes).
- BIOS arms and kicks the timer through LPC writes. If BIOS stalls, the block raises a timed reset request and toggles the BIOS-image select for dual-BIOS failover.
- It runs entirely in the 33 MHz `LpcClock` domain.

Parameters:
- `TICK_DIV`, 33000, `LpcClock` cycles per timebase tick (1 ms at 33 MHz); must be ≥2.
- `TIMEOUT_UNIT`, 1024, ticks per timeout-select step.
- `RST_PULSE`, 16, width of `ResetReq` in `LpcClock` cycles; must be ≥1.
- `CNT_W`, 15, width of the tick down-counter; must hold 16*`TIMEOUT_UNIT`.

Ports:
- `LpcClock`  in  1  33 MHz LPC clock; the only clock.
- `PciReset`  in  1  reset; synchronous, active-high.
- `WriteBiosWD`  in  1  single-cycle write strobe for watchdog register 0x01.
- `DataWr`  in  8  write data, valid while `WriteBiosWD`=1.
- `WdEnabled`  out  1  state ≠ IDLE.
- `WdExpired`  out  1  sticky expiry flag.
- `ResetReq`  out  1  platform reset request pulse.
- `BiosSwap`  out  1  BIOS image select; toggles on each expiry.
- `ExpireCnt`  out  2  saturating expiry count.
- `RemainTicks`  out  `CNT_W`  current down-counter value, for readback.

Behaviour:
- Clock and reset:
  - One clock, `LpcClock`. `PciReset` is synchronous and active-high.
  - While reset is asserted, all state clears on the next edge: state=IDLE, prescaler=0, `RemainTicks`=0, `WdEnabled`=0, `WdExpired`=0, `ResetReq`=0, `ResetReq` counter=0, `BiosSwap`=0, `ExpireCnt`=0.
  - Reset mid-pulse terminates `ResetReq` immediately.
- Write decode (only when `WriteBiosWD`=1):
  - `DataWr[7]` = Enable.
  - `DataWr[6]` = ClearExpired.
  - `DataWr[5:4]` = reserved, ignored.
  - `DataWr[3:0]` = Sel. Reload value = (Sel+1)*`TIMEOUT_UNIT`.
- State machine, states IDLE / ARMED / EXPIRED:
  - Any state, write with Enable=0 → IDLE; `RemainTicks`=0, prescaler=0. `WdExpired` is cleared only if ClearExpired=1.
  - IDLE, write with Enable=1 → ARMED; `RemainTicks`=reload, prescaler=0, effective next cycle.
  - ARMED, write with Enable=1 (kick) → stays ARMED; same reload, prescaler=0.
  - ARMED, tick with `RemainTicks`=1 and no write this cycle → EXPIRED; `RemainTicks`=0.
  - EXPIRED, write with Enable=1 and ClearExpired=1 → ARMED with reload, `WdExpired`=0.
  - EXPIRED, write with Enable=1 and ClearExpired=0 → ignored; stays EXPIRED.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 only in ARMED and holds 0 otherwise.
  - A tick is the cycle in which prescaler=`TICK_DIV`-1; the prescaler wraps to 0 on that cycle.
  - Each tick in ARMED decrements `RemainTicks` by 1.
- Expiry latency: with a write at cycle N, the last tick falls at N+reload*`TICK_DIV`. The expiry outputs appear the following cycle, N+reload*`TICK_DIV`+1.
- Expiry actions, all in the same cycle the state enters EXPIRED:
  - `WdExpired`=1.
  - `BiosSwap` toggles.
  - `ExpireCnt` increments, saturating at 3.
  - `ResetReq`=1 for exactly `RST_PULSE` cycles, driven by its own counter, independent of later writes.
- Simultaneous events:
  - A write in the expiry-tick cycle wins: the reload is applied and no expiry occurs.
  - A reset in any cycle wins over everything.
- `ExpireCnt` and `BiosSwap` are not cleared by ClearExpired; only `PciReset` clears them.
- Wrap-around: `RemainTicks` never underflows; it stops at 0.

Test Plan (`TICK_DIV`=4, `TIMEOUT_UNIT`=8, `RST_PULSE`=3):
1. Reset release, no writes for 100 cycles → all outputs 0, state IDLE.
2. Write 0x80 at cycle N → `WdEnabled`=1 at N+1, `RemainTicks`=8. Expiry at N+33: `WdExpired`=1, `BiosSwap`=1, `ExpireCnt`=1. `ResetReq` high for cycles N+33..N+35, then low.
3. Write 0x81, then kick with 0x81 every 40 cycles for 500 cycles → `WdExpired` stays 0. `RemainTicks` reloads to 16 the cycle after each kick.
4. Write 0x80 at N, plus a write 0x80 exactly at N+32 (expiry tick) → no expiry. `RemainTicks`=8 at N+33.
5. After an expiry: write 0x80 → still EXPIRED. Write 0xC0 → ARMED, `WdExpired`=0, `ExpireCnt` still 1. Let it expire three more times → `ExpireCnt`=3 (saturated), `BiosSwap` toggled each time.
6. Assert `PciReset` one cycle in the middle of a `ResetReq` pulse → the next cycle `ResetReq`=0, `BiosSwap`=0, `ExpireCnt`=0, `WdExpired`=0, state IDLE. A write of 0x00 in ARMED also → IDLE with `RemainTicks`=0.
